// File: rtl/alu_result_checker_if.sv
// rtl/alu_result_checker_if.sv - tuple handshake bundle between the ALU side and the result checker
//
// Signals (N = operand/result width):
//   in_valid  tuple present (master -> slave)
//   in_ready  checker accepts tuple this cycle (slave -> master)
//   in_a/in_b ALU operands, in_op ALU opcode, in_y ALU result, in_zero ALU zero flag
// Modports: master drives the tuple, slave (the checker) drives in_ready.

interface alu_result_checker_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [2:0]   in_op;
  logic [N-1:0] in_y;
  logic         in_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, in_y, in_zero,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_y, in_zero,
    output in_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - on-chip golden-model checker for the single-cycle ALU
//
// Parameters: N (operand/result width), CNT_W (pass/error counter width).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_if (slave)    tuple handshake: in_valid/in_ready, in_a, in_b, in_op, in_y, in_zero
//   start            one-cycle pulse: clear counters and first-error record, enter CHECK
//   halt_on_err      first mismatch moves the checker to HALT
//   err_pulse        one-cycle pulse per detected mismatch
//   pass_cnt/err_cnt saturating match/mismatch counts
//   first_err_*      opcode, observed and expected result of the first failing tuple
//   busy, halted     CHECK or pipeline occupied / state is HALT
// Build option: define ALU_RESULT_CHECKER_ZERO_EN to also check in_zero against
// (expected == 0); left undefined, in_zero is ignored.
//
// Pipeline: accept edge k -> stage 1 (tuple + golden result) -> stage 2 (compare flag)
// at k+1 -> counters, err_pulse, first-error record and state update at k+2.

module alu_result_checker #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_checker_if.slave  in_if,
  input  logic                 start,
  input  logic                 halt_on_err,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 first_err_vld,
  output logic [2:0]           first_err_op,
  output logic [N-1:0]         first_err_y,
  output logic [N-1:0]         first_err_exp,
  output logic                 busy,
  output logic                 halted
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   in_ready_q;
  logic   accept;

  // Stage 1: captured tuple and golden result
  logic         s1_vld;
  logic [2:0]   s1_op;
  logic [N-1:0] s1_y;
  logic [N-1:0] s1_exp;
  logic         s1_illegal;
`ifdef ALU_RESULT_CHECKER_ZERO_EN
  logic         s1_zero;
`endif

  // Stage 2: registered compare outcome
  logic         s2_vld;
  logic         s2_mis;
  logic [2:0]   s2_op;
  logic [N-1:0] s2_y;
  logic [N-1:0] s2_exp;

  logic [N-1:0] exp_c;
  logic         illegal_c;
  logic         mis_c;

  // start wins over a tuple offered in the same cycle, so that tuple is dropped
  assign accept         = in_if.in_valid && in_ready_q && !start;
  assign in_if.in_ready = in_ready_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt == ST_CHECK);
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_CHECK;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_CHECK: if (s2_vld && s2_mis && halt_on_err) state_nxt = ST_HALT;
        ST_HALT:  state_nxt = ST_HALT;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- golden model ----------------
  always_comb begin
    exp_c     = '0;
    illegal_c = 1'b0;
    case (in_if.in_op)
      3'b000:  exp_c = in_if.in_a + in_if.in_b;
      3'b001:  exp_c = in_if.in_a - in_if.in_b;
      3'b010:  exp_c = in_if.in_a & in_if.in_b;
      3'b011:  exp_c = in_if.in_a | in_if.in_b;
      3'b100:  exp_c = in_if.in_a ^ in_if.in_b;
      3'b101:  exp_c = {{(N-1){1'b0}}, ($signed(in_if.in_a) < $signed(in_if.in_b))};
      3'b110:  exp_c = in_if.in_a << in_if.in_b[4:0];
      default: illegal_c = 1'b1;
    endcase
  end

  // Stage-2 compare; an illegal opcode is a mismatch whatever in_y says
  always_comb begin
    mis_c = s1_illegal || (s1_y != s1_exp);
`ifdef ALU_RESULT_CHECKER_ZERO_EN
    if (s1_zero != (s1_exp == '0)) mis_c = 1'b1;
`endif
  end

  // ---------------- pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_op      <= '0;
      s1_y       <= '0;
      s1_exp     <= '0;
      s1_illegal <= 1'b0;
`ifdef ALU_RESULT_CHECKER_ZERO_EN
      s1_zero    <= 1'b0;
`endif
      s2_vld     <= 1'b0;
      s2_mis     <= 1'b0;
      s2_op      <= '0;
      s2_y       <= '0;
      s2_exp     <= '0;
    end else if (start) begin
      // Restart discards whatever is in flight
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_op      <= in_if.in_op;
        s1_y       <= in_if.in_y;
        s1_exp     <= exp_c;
        s1_illegal <= illegal_c;
`ifdef ALU_RESULT_CHECKER_ZERO_EN
        s1_zero    <= in_if.in_zero;
`endif
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mis <= mis_c;
        s2_op  <= s1_op;
        s2_y   <= s1_y;
        s2_exp <= s1_exp;
      end
    end
  end

  // ---------------- counters and first-error record ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse     <= 1'b0;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_op  <= '0;
      first_err_y   <= '0;
      first_err_exp <= '0;
    end else if (start) begin
      err_pulse     <= 1'b0;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_op  <= '0;
      first_err_y   <= '0;
      first_err_exp <= '0;
    end else begin
      err_pulse <= s2_vld && s2_mis;
      if (s2_vld) begin
        if (s2_mis) begin
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
          // Record freezes on the first failure until the next start
          if (!first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_op  <= s2_op;
            first_err_y   <= s2_y;
            first_err_exp <= s2_exp;
          end
        end else if (pass_cnt != CNT_MAX) begin
          pass_cnt <= pass_cnt + CNT_ONE;
        end
      end
    end
  end

  assign busy   = (state == ST_CHECK) || s1_vld || s2_vld;
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - directed self-checking bench for alu_result_checker (CNT_W = 4)

module tb_alu_result_checker;

  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             halt_on_err;
  logic             err_pulse;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             first_err_vld;
  logic [2:0]       first_err_op;
  logic [N-1:0]     first_err_y;
  logic [N-1:0]     first_err_exp;
  logic             busy;
  logic             halted;

  int checks = 0;
  int errors = 0;

  alu_result_checker_if #(.N(N)) bus ();

  alu_result_checker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_if         (bus),
    .start         (start),
    .halt_on_err   (halt_on_err),
    .err_pulse     (err_pulse),
    .pass_cnt      (pass_cnt),
    .err_cnt       (err_cnt),
    .first_err_vld (first_err_vld),
    .first_err_op  (first_err_op),
    .first_err_y   (first_err_y),
    .first_err_exp (first_err_exp),
    .busy          (busy),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] y, input logic z = 1'b0);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_y     = y;
    bus.in_zero  = z;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    halt_on_err  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_op    = '0;
    bus.in_y     = '0;
    bus.in_zero  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_fvld", first_err_vld, 0);
    check("rst_fexp", first_err_exp, 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", bus.in_ready, 0);

    // IDLE -> CHECK
    pulse_start();
    check("start_in_ready", bus.in_ready, 1);
    check("start_busy", busy, 1);

    // 5 + 7 = 12, visible two edges after acceptance
    send(3'b000, 32'd5, 32'd7, 32'd12);
    check("lat_k0_pass", pass_cnt, 0);
    tick();
    check("lat_k1_pass", pass_cnt, 0);
    check("lat_k1_pulse", err_pulse, 0);
    tick();
    check("lat_k2_pass", pass_cnt, 1);
    check("lat_k2_err", err_cnt, 0);
    check("lat_k2_pulse", err_pulse, 0);

    // Back-to-back: wrap-around sub, signed compare, or, xor, shift
    send(3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF);
    send(3'b101, 32'hFFFF_FFFF, 32'd0, 32'd1);
    send(3'b011, 32'hF0, 32'h0F, 32'hFF);
    send(3'b100, 32'hFF, 32'h0F, 32'hF0);
    send(3'b110, 32'd1, 32'd33, 32'd2);
    tick();
    tick();
    check("ops_pass", pass_cnt, 6);
    check("ops_err", err_cnt, 0);

    // Illegal opcode is always a mismatch, expected value 0
    send(3'b111, 32'd3, 32'd4, 32'd9);
    tick();
    tick();
    check("ill_pulse", err_pulse, 1);
    check("ill_err", err_cnt, 1);
    check("ill_pass", pass_cnt, 6);
    check("ill_fvld", first_err_vld, 1);
    check("ill_fop", first_err_op, 7);
    check("ill_fexp", first_err_exp, 0);
    check("ill_fy", first_err_y, 9);
    tick();
    check("ill_pulse_end", err_pulse, 0);

    // Second error counts but leaves the record frozen
    send(3'b000, 32'd1, 32'd1, 32'd5);
    tick();
    tick();
    check("err2_cnt", err_cnt, 2);
    check("err2_fop", first_err_op, 7);
    check("err2_fy", first_err_y, 9);
    check("err2_fexp", first_err_exp, 0);
    check("err2_no_halt", halted, 0);
    check("err2_in_ready", bus.in_ready, 1);

    // In-flight tuple discarded by start; tuple offered with start not accepted
    send(3'b000, 32'd2, 32'd2, 32'd4);
    bus.in_op    = 3'b000;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd1;
    bus.in_y     = 32'd2;
    bus.in_valid = 1'b1;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    check("rs_pass", pass_cnt, 0);
    check("rs_err", err_cnt, 0);
    check("rs_fvld", first_err_vld, 0);
    check("rs_fy", first_err_y, 0);
    tick();
    tick();
    tick();
    check("rs_drop_pass", pass_cnt, 0);
    check("rs_drop_err", err_cnt, 0);
    check("rs_busy", busy, 1);

    // halt_on_err: 2nd of 4 wrong (F0 & 3C = 30, ALU says FF)
    halt_on_err = 1'b1;
    send(3'b000, 32'd1, 32'd2, 32'd3);
    send(3'b010, 32'hF0, 32'h3C, 32'hFF);
    send(3'b011, 32'd1, 32'd2, 32'd3);
    send(3'b100, 32'd3, 32'd1, 32'd2);
    check("halt_halted", halted, 1);
    check("halt_in_ready", bus.in_ready, 0);
    check("halt_pulse", err_pulse, 1);
    check("halt_err", err_cnt, 1);
    check("halt_pass_early", pass_cnt, 1);
    check("halt_fop", first_err_op, 2);
    check("halt_fexp", first_err_exp, 32'h30);
    check("halt_fy", first_err_y, 32'hFF);
    // A fifth tuple waits in vain
    bus.in_op    = 3'b000;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd1;
    bus.in_y     = 32'd2;
    bus.in_valid = 1'b1;
    tick();
    check("halt_pulse_once", err_pulse, 0);
    check("halt_pass_t3", pass_cnt, 2);
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("halt_pass_final", pass_cnt, 3);
    check("halt_err_final", err_cnt, 1);
    check("halt_in_ready_hold", bus.in_ready, 0);
    check("halt_busy", busy, 0);

    // HALT -> CHECK
    halt_on_err = 1'b0;
    pulse_start();
    check("rst2_halted", halted, 0);
    check("rst2_in_ready", bus.in_ready, 1);
    check("rst2_err", err_cnt, 0);
    check("rst2_fvld", first_err_vld, 0);

    // Saturation at 2^CNT_W - 1
    for (int i = 0; i < 20; i++) send(3'b000, i, 32'd1, i + 1);
    tick();
    tick();
    check("sat_pass", pass_cnt, 15);
    check("sat_err", err_cnt, 0);

    // Zero flag: 1 + (-1) = 0 with in_zero = 0
    pulse_start();
    send(3'b000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    tick();
`ifdef ALU_RESULT_CHECKER_ZERO_EN
    check("zero_err", err_cnt, 1);
    check("zero_pass", pass_cnt, 0);
`else
    check("zero_err", err_cnt, 0);
    check("zero_pass", pass_cnt, 1);
`endif

    // Asynchronous reset mid-operation
    send(3'b000, 32'd3, 32'd3, 32'd6);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pass", pass_cnt, 0);
    check("arst_err", err_cnt, 0);
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_fvld", first_err_vld, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_after_pass", pass_cnt, 0);
    check("arst_after_halted", halted, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Hardware result checker for the single-cycle 32-bit ALU. It samples each issued operand/opcode/result tuple over a valid/ready handshake. It recomputes the golden result in a two-stage pipeline, counts passes and mismatches, and latches the first failing tuple for debug. It sits beside the ALU on the datapath and provides on-chip self-check for the operand sweeps the team runs against the ALU.

## Interface
- N, default 32: operand/result width.
- CNT_W, default 16: width of the pass and error counters.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; clears counters and first-error record, enters CHECK.
- halt_on_err  input  1  when 1, the first mismatch moves the checker to HALT.
- in_valid  input  1  tuple present.
- in_ready  output  1  checker accepts tuple this cycle.
- in_a, in_b  input  N  ALU operands.
- in_op  input  3  ALU opcode.
- in_y  input  N  ALU result under test.
- in_zero  input  1  ALU zero flag under test.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- pass_cnt, err_cnt  output  CNT_W  saturating counts of matching and mismatching tuples.
- first_err_vld  output  1  first-error record is valid.
- first_err_op  output  3  opcode of the first failing tuple.
- first_err_y  output  N  in_y of the first failing tuple.
- first_err_exp  output  N  expected result of the first failing tuple.
- busy  output  1  state is CHECK or the pipeline holds a tuple.
- halted  output  1  state is HALT.

## Operation
- States: IDLE (reset state), CHECK, HALT.
  - IDLE → CHECK on start.
  - CHECK → HALT when a mismatch is detected and halt_on_err = 1.
  - HALT → CHECK on start.
  - start in CHECK restarts: counters and record are cleared, and any tuple in flight is discarded.
- in_ready = 1 only in CHECK. A tuple is accepted when in_valid && in_ready.
- Golden model (in_op encoding):
  - 000: a+b
  - 001: a−b
  - 010: a&b
  - 011: a|b
  - 100: a^b
  - 101: signed a<b, zero-extended to N
  - 110: a<<b[4:0]
  - 111: illegal; always counted as a mismatch with expected value 0.
- Arithmetic is modulo 2^N; carries and overflow are ignored.
- Stage 1 registers the tuple and the expected result. Stage 2 compares in_y against the expected result.
- pass_cnt and err_cnt saturate at 2^CNT_W−1 and never wrap.
- First-error record:
  - Loaded only when first_err_vld = 0, then frozen.
  - first_err_vld stays high until start or reset.
- Tuples in the pipeline when HALT is entered are still compared and counted; no new tuples are accepted.

## Timing
- Reset values: all counters 0; all first_err fields 0; first_err_vld 0; err_pulse 0; in_ready 0; busy 0; halted 0; state IDLE.
- Latency: a tuple accepted at edge k produces err_pulse and the counter update visible after edge k+2.
- Throughput is one tuple per cycle with no bubbles.
- in_ready is a registered function of state. Its deassertion on a mismatch takes effect after the edge that registers the stage-2 compare, so up to two further tuples may be accepted after the failing one; these are also checked.
- start has priority over every other event in the same cycle.
- An asynchronous rst_n assertion mid-operation clears everything immediately. Nothing survives reset.

## Configuration
- ALU_RESULT_CHECKER_ZERO_EN defined: stage 2 also requires in_zero == (expected == 0); a zero-flag mismatch counts as an error.
- Macro undefined: in_zero is ignored; only in_y is compared.

## Test plan
- Reset then start; feed op=000, a=5, b=7, y=12 → pass_cnt=1, err_cnt=0, err_pulse never high, result visible 2 cycles after acceptance.
- op=001, a=0, b=1, y=32'hFFFF_FFFF → pass (wrap-around); then op=101, a=32'hFFFF_FFFF, b=0, y=1 → pass (signed compare).
- halt_on_err=1; stream of 4 tuples with the 2nd wrong (op=010, a=F0, b=3C, y=FF instead of 30):
  - err_pulse once; halted=1; first_err_exp=0x30, first_err_y=0xFF.
  - The tuples accepted after the bad one are still counted.
  - in_ready=0 afterwards.
- CNT_W=4; 20 matching tuples → pass_cnt holds at 15.
- op=111 with any operands → err_cnt increments. Then start, asserted in the same cycle as in_valid, clears counters and first_err_vld, and that tuple is not counted.
- With ALU_RESULT_CHECKER_ZERO_EN: op=000, a=1, b=−1, y=0, in_zero=0 → error; without the macro → pass.
